cdc_fifo_bridge: RTL and testbench

Parametrised memory-mapped bridge between the pako32 CPU data bus and the USB_CDC byte streams. It holds one IN FIFO (CPU → host) and one OUT FIFO (host → CPU), each of configurable depth. It adds level and space threshold interrupts, sticky overflow and underflow flags, and software flush, all through a four-register window. The bridge sits in the app level between the CPU load/store path and the USB_CDC `in_*` and `out_*` ports, and replaces the fixed fifo_if.

---
 rtl/cdc_fifo_bridge.sv | 171 +++++++++++++++++
 tb/tb_cdc_fifo_bridge.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/cdc_fifo_bridge.sv
// CPU memory-mapped bridge to the USB_CDC byte streams: IN FIFO (CPU -> host), OUT FIFO
// (host -> CPU), threshold interrupts, sticky OVF/UDF flags and flush via four registers.
module cdc_fifo_bridge #(
  parameter int unsigned IN_DEPTH  = 16,
  parameter int unsigned OUT_DEPTH = 16
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        sel_i,
  input  logic        read_i,
  input  logic        write_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        in_irq_o,
  output logic        out_irq_o,
  output logic [7:0]  in_data_o,
  output logic        in_valid_o,
  input  logic        in_ready_i,
  input  logic [7:0]  out_data_i,
  input  logic        out_valid_i,
  output logic        out_ready_o
);

  localparam int unsigned IN_AW  = $clog2(IN_DEPTH);
  localparam int unsigned IN_CW  = IN_AW + 1;
  localparam int unsigned OUT_AW = $clog2(OUT_DEPTH);
  localparam int unsigned OUT_CW = OUT_AW + 1;

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_CTRL   = 2'd2;
  localparam logic [1:0] A_CLR    = 2'd3;

  logic [7:0]        in_mem [IN_DEPTH];
  logic [IN_AW-1:0]  in_wr_ptr, in_rd_ptr;
  logic [IN_CW-1:0]  in_count, in_count_next;
  logic [7:0]        out_mem [OUT_DEPTH];
  logic [OUT_AW-1:0] out_wr_ptr, out_rd_ptr;
  logic [OUT_CW-1:0] out_count, out_count_next;

  logic [7:0] out_thr, in_thr;
  logic       out_irq_en, in_irq_en;
  logic       ovf, udf;

  logic rd_c, wr_c, rd_data_c, wr_data_c, wr_ctrl_c, wr_clr_c;
  logic in_full_c, in_empty_c, out_full_c, out_empty_c;
  logic in_push_c, in_pop_c, in_flush_c, out_push_c, out_pop_c, out_flush_c;
  logic [7:0]  out_thr_eff_c, in_thr_eff_c;
  logic [8:0]  in_space_c;
  logic [31:0] rdata_c;
  logic        unused_bits_c;

  assign rd_c      = sel_i & read_i;
  assign wr_c      = sel_i & write_i;
  assign rd_data_c = rd_c & (addr_i == A_DATA);
  assign wr_data_c = wr_c & (addr_i == A_DATA);
  assign wr_ctrl_c = wr_c & (addr_i == A_CTRL);
  assign wr_clr_c  = wr_c & (addr_i == A_CLR);
  assign unused_bits_c = ^data_i[31:20];

  assign in_full_c   = (in_count == IN_CW'(IN_DEPTH));
  assign in_empty_c  = (in_count == '0);
  assign out_full_c  = (out_count == OUT_CW'(OUT_DEPTH));
  assign out_empty_c = (out_count == '0);

  assign in_valid_o  = ~in_empty_c;
  assign in_data_o   = in_mem[in_rd_ptr];
  assign out_ready_o = ~out_full_c;

  // Full/empty gating always uses the pre-edge count; flush overrides both sides.
  assign in_push_c   = wr_data_c & ~in_full_c;
  assign in_pop_c    = in_valid_o & in_ready_i;
  assign in_flush_c  = wr_ctrl_c & data_i[18];
  assign out_push_c  = out_valid_i & out_ready_o;
  assign out_pop_c   = rd_data_c & ~out_empty_c;
  assign out_flush_c = wr_ctrl_c & data_i[19];

  always_comb begin
    in_count_next = in_count;
    if (in_flush_c)                 in_count_next = '0;
    else if (in_push_c && !in_pop_c) in_count_next = in_count + IN_CW'(1);
    else if (!in_push_c && in_pop_c) in_count_next = in_count - IN_CW'(1);
  end

  always_comb begin
    out_count_next = out_count;
    if (out_flush_c)                   out_count_next = '0;
    else if (out_push_c && !out_pop_c) out_count_next = out_count + OUT_CW'(1);
    else if (!out_push_c && out_pop_c) out_count_next = out_count - OUT_CW'(1);
  end

  // A zero threshold behaves as one.
  assign out_thr_eff_c = (out_thr == 8'd0) ? 8'd1 : out_thr;
  assign in_thr_eff_c  = (in_thr == 8'd0) ? 8'd1 : in_thr;
  assign in_space_c    = 9'(IN_DEPTH) - 9'(in_count_next);

  always_comb begin
    rdata_c = '0;
    case (addr_i)
      A_DATA:   rdata_c = out_empty_c ? 32'd0 : {24'd0, out_mem[out_rd_ptr]};
      A_STATUS: rdata_c = {10'd0, udf, ovf, out_empty_c, out_full_c, in_empty_c, in_full_c,
                           8'(in_count), 8'(out_count)};
      A_CTRL:   rdata_c = {14'd0, in_irq_en, out_irq_en, in_thr, out_thr};
      A_CLR:    rdata_c = '0;
      default:  rdata_c = '0;
    endcase
  end

  // Payload storage carries no reset.
  always_ff @(posedge clk_i) begin
    if (in_push_c && !in_flush_c)   in_mem[in_wr_ptr]   <= data_i[7:0];
    if (out_push_c && !out_flush_c) out_mem[out_wr_ptr] <= out_data_i;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      in_wr_ptr  <= '0;
      in_rd_ptr  <= '0;
      in_count   <= '0;
      out_wr_ptr <= '0;
      out_rd_ptr <= '0;
      out_count  <= '0;
    end else begin
      in_count  <= in_count_next;
      out_count <= out_count_next;
      if (in_flush_c) begin
        in_wr_ptr <= '0;
        in_rd_ptr <= '0;
      end else begin
        if (in_push_c) in_wr_ptr <= in_wr_ptr + IN_AW'(1);
        if (in_pop_c)  in_rd_ptr <= in_rd_ptr + IN_AW'(1);
      end
      if (out_flush_c) begin
        out_wr_ptr <= '0;
        out_rd_ptr <= '0;
      end else begin
        if (out_push_c) out_wr_ptr <= out_wr_ptr + OUT_AW'(1);
        if (out_pop_c)  out_rd_ptr <= out_rd_ptr + OUT_AW'(1);
      end
    end
  end

  // Control, sticky flags, read data and interrupts.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      out_thr    <= 8'd1;
      in_thr     <= 8'd1;
      out_irq_en <= 1'b0;
      in_irq_en  <= 1'b0;
      ovf        <= 1'b0;
      udf        <= 1'b0;
      data_o     <= '0;
      in_irq_o   <= 1'b0;
      out_irq_o  <= 1'b0;
    end else begin
      if (wr_ctrl_c) begin
        out_thr    <= data_i[7:0];
        in_thr     <= data_i[15:8];
        out_irq_en <= data_i[16];
        in_irq_en  <= data_i[17];
      end
      ovf <= (wr_data_c & in_full_c) | (ovf & ~(wr_clr_c & data_i[0]));
      udf <= (rd_data_c & out_empty_c) | (udf & ~(wr_clr_c & data_i[1]));
      if (rd_c) data_o <= rdata_c;
      out_irq_o <= out_irq_en & (9'(out_count_next) >= 9'(out_thr_eff_c));
      in_irq_o  <= in_irq_en & (in_space_c >= 9'(in_thr_eff_c));
    end
  end

endmodule

// File: tb/tb_cdc_fifo_bridge.sv
// Directed self-checking bench for cdc_fifo_bridge with 4-entry FIFOs.
module tb_cdc_fifo_bridge;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        sel_i, read_i, write_i;
  logic [1:0]  addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        in_irq_o, out_irq_o;
  logic [7:0]  in_data_o;
  logic        in_valid_o, in_ready_i;
  logic [7:0]  out_data_i;
  logic        out_valid_i, out_ready_o;

  int n_checks = 0;
  int n_fail   = 0;

  cdc_fifo_bridge #(.IN_DEPTH(4), .OUT_DEPTH(4)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .sel_i(sel_i), .read_i(read_i), .write_i(write_i),
    .addr_i(addr_i), .data_i(data_i), .data_o(data_o), .in_irq_o(in_irq_o),
    .out_irq_o(out_irq_o), .in_data_o(in_data_o), .in_valid_o(in_valid_o),
    .in_ready_i(in_ready_i), .out_data_i(out_data_i), .out_valid_i(out_valid_i),
    .out_ready_o(out_ready_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    sel_i = 1'b1; write_i = 1'b1; addr_i = a; data_i = d;
    cyc();
    sel_i = 1'b0; write_i = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    sel_i = 1'b1; read_i = 1'b1; addr_i = a;
    cyc();
    sel_i = 1'b0; read_i = 1'b0;
    d = data_o;
  endtask

  logic [31:0] rv;
  logic [7:0]  q[$];
  logic [7:0]  val;
  logic        wr, pop_m, push_m;

  initial begin
    rstn_i = 1'b0; sel_i = 1'b0; read_i = 1'b0; write_i = 1'b0; addr_i = 2'd0;
    data_i = '0; in_ready_i = 1'b0; out_data_i = '0; out_valid_i = 1'b0;
    repeat (2) cyc();
    check("rst data_o", data_o, 32'h0);
    check("rst in_valid", 32'(in_valid_o), 32'h0);
    check("rst out_ready", 32'(out_ready_o), 32'h1);
    check("rst irqs", {30'd0, in_irq_o, out_irq_o}, 32'h0);
    rstn_i = 1'b1;
    cyc();
    bus_read(2'd1, rv);
    check("rst status", rv, 32'h000A_0000);
    bus_read(2'd2, rv);
    check("rst ctrl", rv, 32'h0000_0101);

    // IN overflow: fifth byte dropped, then drain at one byte per cycle
    for (int i = 0; i < 5; i++) bus_write(2'd0, 32'h11 + 32'(i));
    bus_read(2'd1, rv);
    check("ovf status", rv, 32'h0019_0400);
    in_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain valid", 32'(in_valid_o), 32'h1);
      check("drain byte", 32'(in_data_o), 32'h11 + 32'(i));
      cyc();
    end
    check("drained valid", 32'(in_valid_o), 32'h0);
    in_ready_i = 1'b0;
    bus_write(2'd3, 32'h1);
    bus_read(2'd1, rv);
    check("ovf cleared", rv, 32'h000A_0000);

    // OUT level interrupt with threshold 3
    bus_write(2'd2, 32'h0001_0103);
    out_valid_i = 1'b1;
    out_data_i = 8'hA0; cyc();
    out_data_i = 8'hA1; cyc();
    check("out_irq 2", 32'(out_irq_o), 32'h0);
    out_data_i = 8'hA2; cyc();
    check("out_irq 3", 32'(out_irq_o), 32'h1);
    out_valid_i = 1'b0;
    bus_read(2'd0, rv);
    check("out rd A0", rv, 32'hA0);
    check("out_irq fall", 32'(out_irq_o), 32'h0);
    bus_read(2'd0, rv);
    check("out rd A1", rv, 32'hA1);
    bus_read(2'd0, rv);
    check("out rd A2", rv, 32'hA2);
    cyc();
    check("data_o hold", data_o, 32'hA2);

    // IN space interrupt with threshold 2 (depth 4)
    bus_write(2'd2, 32'h0002_0201);
    cyc();
    check("in_irq empty", 32'(in_irq_o), 32'h1);
    bus_write(2'd0, 32'h21);
    bus_write(2'd0, 32'h22);
    check("in_irq space2", 32'(in_irq_o), 32'h1);
    bus_write(2'd0, 32'h23);
    check("in_irq space1", 32'(in_irq_o), 32'h0);

    // Flush IN while USB is popping
    in_ready_i = 1'b1;
    bus_write(2'd2, 32'h0004_0101);
    in_ready_i = 1'b0;
    check("flush valid", 32'(in_valid_o), 32'h0);
    bus_read(2'd1, rv);
    check("flush status", rv, 32'h000A_0000);
    bus_read(2'd2, rv);
    check("flush ctrl", rv, 32'h0000_0101);

    // Underflow, clear, then underflow with a same-cycle host push
    bus_read(2'd0, rv);
    check("udf data", rv, 32'h0);
    bus_read(2'd1, rv);
    check("udf status", rv, 32'h002A_0000);
    bus_write(2'd3, 32'h2);
    bus_read(2'd1, rv);
    check("udf cleared", rv, 32'h000A_0000);
    out_valid_i = 1'b1; out_data_i = 8'h55;
    bus_read(2'd0, rv);
    out_valid_i = 1'b0;
    check("udf push data", rv, 32'h0);
    bus_read(2'd1, rv);
    check("udf push status", rv, 32'h0022_0001);
    bus_read(2'd0, rv);
    check("late byte", rv, 32'h55);
    bus_write(2'd3, 32'h2);

    // Wrap-around: write 6, drain 5, random in_ready, checked against a queue model
    val = 8'h40;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 11; c++) begin
        wr = (c < 6);
        in_ready_i = 1'($urandom_range(0, 1));
        sel_i = wr; write_i = wr; addr_i = 2'd0; data_i = 32'(val);
        check("wrap valid", 32'(in_valid_o), 32'(q.size() > 0));
        pop_m  = (q.size() > 0) && in_ready_i;
        push_m = wr && (q.size() < 4);
        if (pop_m) check("wrap byte", 32'(in_data_o), 32'(q[0]));
        if (r == 3 && c == 3) begin
          #2 rstn_i = 1'b0;
          #1;
          break;
        end
        cyc();
        if (pop_m) void'(q.pop_front());
        if (push_m) q.push_back(val);
        if (wr) val = val + 8'd1;
      end
    end
    sel_i = 1'b0; write_i = 1'b0; in_ready_i = 1'b0;
    check("mid rst data_o", data_o, 32'h0);
    check("mid rst in_valid", 32'(in_valid_o), 32'h0);
    check("mid rst out_ready", 32'(out_ready_o), 32'h1);
    check("mid rst irqs", {30'd0, in_irq_o, out_irq_o}, 32'h0);
    cyc();
    rstn_i = 1'b1;
    cyc();
    bus_read(2'd1, rv);
    check("post rst status", rv, 32'h000A_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
